// File: rtl/insn_sequencer.sv
// Instruction sequencer: fetches one byte per instruction from program memory,
// decodes its class and pulses one class strobe, with a fetch timeout that parks in FAULT.
module insn_sequencer #(
    parameter int unsigned UUID          = 0,
    parameter string       NAME          = "",
    parameter int unsigned FETCH_TIMEOUT = 15
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       halt_req,
    output logic       mem_req,
    output logic [7:0] mem_addr,
    input  logic       mem_ack,
    input  logic [7:0] mem_data,
    input  logic       cond_true,
    input  logic [7:0] jump_target,
    output logic [7:0] instr,
    output logic       imm_en,
    output logic       calc_en,
    output logic       copy_en,
    output logic       cond_en,
    output logic [7:0] pc,
    output logic       busy,
    output logic       fault
);

    // state  | meaning
    // IDLE   | waiting for start, pc retained
    // FETCH  | mem_req high, waiting for mem_ack or timeout
    // DECODE | one quiet cycle after the fetch
    // EXEC   | one class strobe, optional branch, halt_req decides next
    // FAULT  | fetch timed out, frozen until rst
    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_FAULT
    } state_t;

    localparam logic [7:0] WAIT_LAST = 8'(FETCH_TIMEOUT - 1);

    state_t     state_q, state_d;
    logic [7:0] pc_q, pc_d;
    logic [7:0] instr_q, instr_d;
    logic [7:0] wait_q, wait_d;
    logic       exec_now;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            pc_q    <= 8'd0;
            instr_q <= 8'd0;
            wait_q  <= 8'd0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
            wait_q  <= wait_d;
        end
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        instr_d = instr_q;
        wait_d  = wait_q;
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_FETCH;
                    wait_d  = 8'd0;
                end
            end
            S_FETCH: begin
                // an ack in the final allowed cycle still completes the fetch
                if (mem_ack) begin
                    instr_d = mem_data;
                    pc_d    = pc_q + 8'd1;
                    state_d = S_DECODE;
                end else begin
                    wait_d = wait_q + 8'd1;
                    if (wait_q == WAIT_LAST) begin
                        state_d = S_FAULT;
                    end
                end
            end
            S_DECODE: begin
                state_d = S_EXEC;
            end
            S_EXEC: begin
                if (instr_q[7:6] == 2'b11 && cond_true) begin
                    pc_d = jump_target;
                end
                if (halt_req) begin
                    state_d = S_IDLE;
                end else begin
                    state_d = S_FETCH;
                    wait_d  = 8'd0;
                end
            end
            S_FAULT: begin
                state_d = S_FAULT;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign exec_now = (state_q == S_EXEC);
    assign mem_req  = (state_q == S_FETCH);
    assign mem_addr = pc_q;
    assign pc       = pc_q;
    assign instr    = instr_q;
    assign busy     = (state_q == S_FETCH) || (state_q == S_DECODE) || (state_q == S_EXEC);
    assign fault    = (state_q == S_FAULT);
    assign imm_en   = exec_now && (instr_q[7:6] == 2'b00);
    assign calc_en  = exec_now && (instr_q[7:6] == 2'b01);
    assign copy_en  = exec_now && (instr_q[7:6] == 2'b10);
    assign cond_en  = exec_now && (instr_q[7:6] == 2'b11);

endmodule
